// File: rtl/fifo_pkg.sv
// fifo_pkg: sizing and pointer helpers shared by the fifo family.
//   fifo_cnt_w(depth)        width able to hold 0..depth inclusive
//   fifo_ptr_w(depth)        width able to index 0..depth-1 (minimum 1)
//   ptr_wrap_inc(ptr, depth) ptr + 1, wrapping depth-1 -> 0 (any depth)
package fifo_pkg;

   function automatic int unsigned fifo_cnt_w(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

   function automatic int unsigned fifo_ptr_w(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Explicit compare instead of relying on natural overflow, so
   // non-power-of-two depths wrap at the right index.
   function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_v4_ptr.sv
// fifo_v4_ptr: wrap-around pointer register for fifo_v4.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (pointer -> 0)
//   inc_i   advance pointer by one, wrapping DEPTH-1 -> 0
//   clr_i   return pointer to 0 (dominates inc_i)
//   ptr_o   current pointer
module fifo_v4_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = fifo_ptr_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [PTR_W-1:0] ptr_o
);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_o <= '0;
      end else if (clr_i) begin
         ptr_o <= '0;
      end else if (inc_i) begin
         ptr_o <= PTR_W'(ptr_wrap_inc(32'(ptr_o), DEPTH));
      end
   end

endmodule

// File: rtl/fifo_v4.sv
// fifo_v4: parametrised ready/valid FIFO with arbitrary depth, exact usage
// count, runtime almost-full/almost-empty thresholds and an optional
// high-water-mark monitor (enabled by defining FIFO_V4_HWM_EN).
//   clk_i / rst_ni          clock, asynchronous active-low reset
//   flush_i                 synchronous flush; blocks both handshakes this cycle
//   valid_i/ready_o/data_i  upstream handshake and payload
//   valid_o/ready_i/data_o  downstream handshake and head payload
//   usage_o                 entries held, 0..DEPTH
//   af_thresh_i/ae_thresh_i thresholds; almost_full_o = usage >= af,
//                           almost_empty_o = usage <= ae
//   hwm_o/hwm_clr_i         (FIFO_V4_HWM_EN) max usage, clear to current usage
module fifo_v4
   import fifo_pkg::*;
#(
   parameter logic         FALL_THROUGH = 1'b0,
   parameter int unsigned  DATA_WIDTH   = 32,
   parameter int unsigned  DEPTH        = 8,
   parameter type          dtype        = logic [DATA_WIDTH-1:0],
   localparam int unsigned CNT_W        = fifo_cnt_w(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  dtype             data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output dtype             data_o,
   output logic [CNT_W-1:0] usage_o,
   input  logic [CNT_W-1:0] af_thresh_i,
   input  logic [CNT_W-1:0] ae_thresh_i,
   output logic             almost_full_o,
   output logic             almost_empty_o
`ifdef FIFO_V4_HWM_EN
  ,output logic [CNT_W-1:0] hwm_o,
   input  logic             hwm_clr_i
`endif
);

   localparam int unsigned PTR_W = fifo_ptr_w(DEPTH);

   if (DEPTH == 0) begin : g_bad_depth
      $error("fifo_v4: DEPTH must be at least 1");
   end

   logic [CNT_W-1:0] count_q, count_n;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   dtype             mem_q [DEPTH];
   logic             full, empty;
   logic             push, pop, bypass, wr_en, rd_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   // ready_o looks at registered state only, so a pop on a full FIFO does
   // not open the input until the following cycle.
   assign ready_o = ~full & ~flush_i;
   assign valid_o = (~empty | (FALL_THROUGH & valid_i)) & ~flush_i;

   assign push = valid_i & ready_o;
   assign pop  = valid_o & ready_i;

   // Fall-through with nothing stored: a same-cycle push and pop hand the
   // word straight across and leave storage untouched.
   assign bypass = FALL_THROUGH & empty & push & pop;
   assign wr_en  = push & ~bypass;
   assign rd_en  = pop & ~bypass;

   assign data_o = (FALL_THROUGH && empty) ? data_i : mem_q[rd_ptr];

   always_comb begin
      count_n = count_q;
      if (flush_i) begin
         count_n = '0;
      end else if (wr_en && !rd_en) begin
         count_n = count_q + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
         count_n = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_n;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_ptr] <= data_i;
      end
   end

   fifo_v4_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_wr_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (wr_en),
      .clr_i  (flush_i),
      .ptr_o  (wr_ptr)
   );

   fifo_v4_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_rd_ptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (rd_en),
      .clr_i  (flush_i),
      .ptr_o  (rd_ptr)
   );

   assign usage_o        = count_q;
   assign almost_full_o  = (count_q >= af_thresh_i);
   assign almost_empty_o = (count_q <= ae_thresh_i);

`ifdef FIFO_V4_HWM_EN
   logic [CNT_W-1:0] hwm_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hwm_q <= '0;
      end else if (hwm_clr_i) begin
         hwm_q <= count_q;
      end else if (count_n > hwm_q) begin
         hwm_q <= count_n;
      end
   end

   assign hwm_o = hwm_q;
`endif

`ifndef SYNTHESIS
   a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i && !ready_o) |=> $stable(data_i));

   a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= CNT_W'(DEPTH));
`endif

endmodule
